sram64x8_arb_ctrl: RTL and testbench

Two-port round-robin access controller in front of one gf180mcu_fd_ip_sram__sram64x8m8wm1 macro. After reset it performs the macro's mandatory CEN 1->0 wake-up sequence and an optional zero-fill. It then arbitrates read/write requests from two requesters onto the single-port macro, at one access per cycle, and returns read data with a fixed latency.

---
 rtl/sram64x8_ctrl_pkg.sv | 17 +
 rtl/rr_arb2.sv | 36 +++
 rtl/sram64x8_arb_ctrl.sv | 168 ++++++++++++++++
 tb/tb_sram64x8_arb_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram64x8_ctrl_pkg.sv
// Shared types and geometry for the gf180 64x8 SRAM access controller.
package sram64x8_ctrl_pkg;

  typedef enum logic [1:0] {HOLD, CLEAR, SERVE} state_e;

  localparam int SRAM_DEPTH = 64;
  localparam int SRAM_AW    = 6;
  localparam int SRAM_DW    = 8;
  localparam int READ_LAT   = 2;

  // One stage of the outstanding-read tracker.
  typedef struct packed {
    logic valid;
    logic port;
  } rd_tag_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; on contention the pointed-to port wins and
// the pointer moves to the loser, so it only changes when both request.
module rr_arb2 (
  input  logic       CLK,
  input  logic       cen_not_rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr_q, ptr_d;

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    gnt   = 2'b00;
    ptr_d = ptr_q;
    if (en) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11: begin
          gnt   = ptr_q ? 2'b10 : 2'b01;
          ptr_d = ~ptr_q;
        end
        default: gnt = 2'b00;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge CLK or posedge cen_not_rst) begin
    if (cen_not_rst) ptr_q <= 1'b0;
    else             ptr_q <= ptr_d;
  end

endmodule

// File: rtl/sram64x8_arb_ctrl.sv
// Wake-up, optional zero-fill and two-port round-robin access to one
// single-port 64x8 SRAM macro, with reads returned two cycles after grant.
module sram64x8_arb_ctrl
  import sram64x8_ctrl_pkg::*;
#(
  parameter int CEN_HOLD = 4,
  parameter bit CLEAR_EN = 1'b1
) (
  input  logic               CLK,
  input  logic               cen_not_rst,
  input  logic               p0_req,
  input  logic               p0_we,
  input  logic [SRAM_AW-1:0] p0_addr,
  input  logic [SRAM_DW-1:0] p0_wdata,
  input  logic [SRAM_DW-1:0] p0_wmask,
  output logic               p0_gnt,
  output logic               p0_rvalid,
  output logic [SRAM_DW-1:0] p0_rdata,
  input  logic               p1_req,
  input  logic               p1_we,
  input  logic [SRAM_AW-1:0] p1_addr,
  input  logic [SRAM_DW-1:0] p1_wdata,
  input  logic [SRAM_DW-1:0] p1_wmask,
  output logic               p1_gnt,
  output logic               p1_rvalid,
  output logic [SRAM_DW-1:0] p1_rdata,
  output logic               ready,
  output logic               sram_cen,
  output logic               sram_gwen,
  output logic [SRAM_DW-1:0] sram_wen,
  output logic [SRAM_AW-1:0] sram_a,
  output logic [SRAM_DW-1:0] sram_d,
  input  logic [SRAM_DW-1:0] sram_q
);

  // cnt serves both the wake-up hold and the clear address sweep.
  localparam int CW = (CEN_HOLD > SRAM_DEPTH) ? $clog2(CEN_HOLD) : SRAM_AW;

  state_e                      state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        ready_q, ready_d;
  logic                        cen_q, cen_d;
  logic                        gwen_q, gwen_d;
  logic [SRAM_DW-1:0]          wen_q, wen_d;
  logic [SRAM_AW-1:0]          a_q, a_d;
  logic [SRAM_DW-1:0]          d_q, d_d;
  rd_tag_t [READ_LAT-1:0]      tag_q, tag_d;

  logic [1:0]                  gnt;
  logic                        any_gnt, sel;
  logic                        sel_we;
  logic [SRAM_AW-1:0]          sel_addr;
  logic [SRAM_DW-1:0]          sel_wdata, sel_wmask;

  rr_arb2 u_arb (
    .CLK         (CLK),
    .cen_not_rst (cen_not_rst),
    .en          (ready_q),
    .req         ({p1_req, p0_req}),
    .gnt         (gnt)
  );

  assign any_gnt   = |gnt;
  assign sel       = gnt[1];
  assign sel_we    = sel ? p1_we    : p0_we;
  assign sel_addr  = sel ? p1_addr  : p0_addr;
  assign sel_wdata = sel ? p1_wdata : p0_wdata;
  assign sel_wmask = sel ? p1_wmask : p0_wmask;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ready_d  = ready_q;
    cen_d    = 1'b1;
    gwen_d   = 1'b1;
    wen_d    = '1;
    a_d      = a_q;
    d_d      = d_q;
    tag_d[0] = '{valid: any_gnt & ~sel_we, port: sel};
    tag_d[1] = tag_q[0];

    unique case (state_q)
      HOLD: begin
        if (cnt_q == CW'(CEN_HOLD - 1)) begin
          cnt_d = '0;
          if (CLEAR_EN) begin
            // The first clear write goes out together with leaving HOLD.
            state_d = CLEAR;
            cen_d   = 1'b0;
            gwen_d  = 1'b0;
            wen_d   = '0;
            a_d     = '0;
            d_d     = '0;
          end else begin
            state_d = SERVE;
            ready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CLEAR: begin
        if (cnt_q == CW'(SRAM_DEPTH - 1)) begin
          state_d = SERVE;
          ready_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d  = cnt_q + 1'b1;
          cen_d  = 1'b0;
          gwen_d = 1'b0;
          wen_d  = '0;
          a_d    = SRAM_AW'(cnt_q + 1'b1);
          d_d    = '0;
        end
      end
      SERVE: begin
        if (any_gnt) begin
          cen_d = 1'b0;
          a_d   = sel_addr;
          d_d   = sel_wdata;
          if (sel_we) begin
            gwen_d = 1'b0;
            wen_d  = ~sel_wmask;
          end
        end
      end
      default: state_d = HOLD;
    endcase
  end

  always_ff @(posedge CLK or posedge cen_not_rst) begin
    if (cen_not_rst) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      cen_q   <= 1'b1;
      gwen_q  <= 1'b1;
      wen_q   <= '1;
      a_q     <= '0;
      d_q     <= '0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      cen_q   <= cen_d;
      gwen_q  <= gwen_d;
      wen_q   <= wen_d;
      a_q     <= a_d;
      d_q     <= d_d;
      tag_q   <= tag_d;
    end
  end

  assign p0_gnt    = gnt[0];
  assign p1_gnt    = gnt[1];
  assign p0_rvalid = tag_q[READ_LAT-1].valid & ~tag_q[READ_LAT-1].port;
  assign p1_rvalid = tag_q[READ_LAT-1].valid &  tag_q[READ_LAT-1].port;
  assign p0_rdata  = sram_q;
  assign p1_rdata  = sram_q;
  assign ready     = ready_q;
  assign sram_cen  = cen_q;
  assign sram_gwen = gwen_q;
  assign sram_wen  = wen_q;
  assign sram_a    = a_q;
  assign sram_d    = d_q;

endmodule

// File: tb/tb_sram64x8_arb_ctrl.sv
// Randomized and directed bench for sram64x8_arb_ctrl against a behavioural
// memory/arbitration model, with a simple SRAM macro model on the sram_* pins.
module tb_sram64x8_arb_ctrl;

  typedef struct packed {
    logic       req;
    logic       we;
    logic [5:0] addr;
    logic [7:0] wdata;
    logic [7:0] wmask;
  } req_t;

  typedef struct {
    int         due;
    int         port;
    logic [7:0] data;
  } exp_t;

  logic       CLK = 1'b0;
  logic       cen_not_rst = 1'b1;
  logic       p0_req = 0, p0_we = 0, p1_req = 0, p1_we = 0;
  logic [5:0] p0_addr = 0, p1_addr = 0;
  logic [7:0] p0_wdata = 0, p0_wmask = 0, p1_wdata = 0, p1_wmask = 0;
  logic       p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, ready;
  logic [7:0] p0_rdata, p1_rdata;
  logic       sram_cen, sram_gwen;
  logic [7:0] sram_wen, sram_d;
  logic [5:0] sram_a;
  logic [7:0] sram_q = 8'h00;

  // Second instance without zero-fill.
  logic       rst2 = 1'b1;
  logic       n_p0_req = 0, n_p1_req = 0;
  logic       n_p0_gnt, n_p1_gnt, n_p0_rvalid, n_p1_rvalid, n_ready;
  logic [7:0] n_p0_rdata, n_p1_rdata, n_wen, n_d;
  logic       n_cen, n_gwen;
  logic [5:0] n_a;
  logic [7:0] n_q = 8'h00;

  always #5 CLK = ~CLK;

  sram64x8_arb_ctrl #(.CEN_HOLD(4), .CLEAR_EN(1'b1)) dut (
    .CLK(CLK), .cen_not_rst(cen_not_rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_wmask(p0_wmask), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_wmask(p1_wmask), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .ready(ready), .sram_cen(sram_cen), .sram_gwen(sram_gwen), .sram_wen(sram_wen),
    .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q)
  );

  sram64x8_arb_ctrl #(.CEN_HOLD(4), .CLEAR_EN(1'b0)) dut_nc (
    .CLK(CLK), .cen_not_rst(rst2),
    .p0_req(n_p0_req), .p0_we(1'b0), .p0_addr(6'd0), .p0_wdata(8'h00),
    .p0_wmask(8'h00), .p0_gnt(n_p0_gnt), .p0_rvalid(n_p0_rvalid), .p0_rdata(n_p0_rdata),
    .p1_req(n_p1_req), .p1_we(1'b0), .p1_addr(6'd1), .p1_wdata(8'h00),
    .p1_wmask(8'h00), .p1_gnt(n_p1_gnt), .p1_rvalid(n_p1_rvalid), .p1_rdata(n_p1_rdata),
    .ready(n_ready), .sram_cen(n_cen), .sram_gwen(n_gwen), .sram_wen(n_wen),
    .sram_a(n_a), .sram_d(n_d), .sram_q(n_q)
  );

  // Macro model: synchronous, Q updates on read, bit-masked write.
  logic [7:0] macro_mem [64];
  always @(posedge CLK) begin
    if (!sram_cen) begin
      if (sram_gwen) sram_q <= macro_mem[sram_a];
      else macro_mem[sram_a] <= (macro_mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
    end
  end

  // Reference model state.
  logic [7:0] ref_mem [64];
  int         favor;
  bit         tb_ready;
  int         cyc;
  exp_t       exp_q[$];
  logic [5:0] hold_a;
  logic [7:0] hold_d;
  int         total = 0;
  int         bad = 0;

  function automatic req_t mk(input logic req, input logic we, input logic [5:0] addr,
                              input logic [7:0] wdata, input logic [7:0] wmask);
    req_t r;
    r.req = req; r.we = we; r.addr = addr; r.wdata = wdata; r.wmask = wmask;
    return r;
  endfunction

  localparam req_t IDLE = '0;

  task automatic model_after_clear();
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
    favor    = 0;
    tb_ready = 1'b1;
    hold_a   = 6'd63;
    hold_d   = 8'h00;
    exp_q.delete();
  endtask

  // One SERVE cycle: drive at negedge, check grant, then check issue and rvalid next negedge.
  task automatic cycle(input req_t r0, input req_t r1, output logic g0, output logic g1);
    int         w;
    req_t       r;
    exp_t       e;
    logic       ecen, egwen, ev0, ev1;
    logic [7:0] ewen, ed, erd;
    logic [5:0] ea;
    p0_req = r0.req; p0_we = r0.we; p0_addr = r0.addr; p0_wdata = r0.wdata; p0_wmask = r0.wmask;
    p1_req = r1.req; p1_we = r1.we; p1_addr = r1.addr; p1_wdata = r1.wdata; p1_wmask = r1.wmask;
    #1;
    w = -1;
    if (tb_ready) begin
      if (r0.req && r1.req) begin w = favor; favor = 1 - favor; end
      else if (r0.req) w = 0;
      else if (r1.req) w = 1;
    end
    g0 = p0_gnt;
    g1 = p1_gnt;
    total++;
    if (p0_gnt !== (w == 0) || p1_gnt !== (w == 1)) begin
      bad++;
      $display("FAIL gnt cyc=%0d got p0=%b p1=%b required winner=%0d", cyc, p0_gnt, p1_gnt, w);
    end
    r = (w == 1) ? r1 : r0;
    if (w >= 0) begin
      if (r.we) ref_mem[r.addr] = (ref_mem[r.addr] & ~r.wmask) | (r.wdata & r.wmask);
      else begin
        e.due = cyc + 2; e.port = w; e.data = ref_mem[r.addr];
        exp_q.push_back(e);
      end
    end
    @(posedge CLK);
    cyc++;
    @(negedge CLK);
    if (w >= 0) begin
      ecen = 1'b0; egwen = ~r.we; ewen = r.we ? ~r.wmask : 8'hFF; ea = r.addr; ed = r.wdata;
      hold_a = ea; hold_d = ed;
    end else begin
      ecen = 1'b1; egwen = 1'b1; ewen = 8'hFF; ea = hold_a; ed = hold_d;
    end
    total++;
    if ({sram_cen, sram_gwen, sram_wen, sram_a, sram_d} !== {ecen, egwen, ewen, ea, ed}) begin
      bad++;
      $display("FAIL issue cyc=%0d got cen=%b gwen=%b wen=%h a=%0d d=%h required cen=%b gwen=%b wen=%h a=%0d d=%h",
               cyc, sram_cen, sram_gwen, sram_wen, sram_a, sram_d, ecen, egwen, ewen, ea, ed);
    end
    ev0 = 1'b0; ev1 = 1'b0; erd = 8'h00;
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      e = exp_q.pop_front();
      ev0 = (e.port == 0); ev1 = (e.port == 1); erd = e.data;
    end
    total++;
    if (p0_rvalid !== ev0 || p1_rvalid !== ev1 || (ev0 && p0_rdata !== erd) || (ev1 && p1_rdata !== erd)) begin
      bad++;
      $display("FAIL rvalid cyc=%0d got v0=%b v1=%b d0=%h d1=%h required v0=%b v1=%b data=%h",
               cyc, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata, ev0, ev1, erd);
    end
  endtask

  task automatic drain(input int n);
    logic g0, g1;
    for (int i = 0; i < n; i++) cycle(IDLE, IDLE, g0, g1);
  endtask

  task automatic test_reset();
    p0_req = 1'b1; p1_req = 1'b1;
    repeat (3) @(negedge CLK);
    total++;
    if ({sram_cen, sram_gwen, sram_wen, sram_a, sram_d} !== {1'b1, 1'b1, 8'hFF, 6'd0, 8'h00}) begin
      bad++;
      $display("FAIL reset_sram got cen=%b gwen=%b wen=%h a=%0d d=%h required 1 1 ff 0 00",
               sram_cen, sram_gwen, sram_wen, sram_a, sram_d);
    end
    total++;
    if ({ready, p0_gnt, p1_gnt, p0_rvalid, p1_rvalid} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctl got ready=%b gnt=%b%b rvalid=%b%b required all 0",
               ready, p0_gnt, p1_gnt, p0_rvalid, p1_rvalid);
    end
    p0_req = 1'b0; p1_req = 1'b0;
  endtask

  // Called at a negedge with reset asserted; releases it and checks the wake-up sequence.
  task automatic test_init();
    logic [18:0] got, req;
    tb_ready = 1'b0;
    cen_not_rst = 1'b0;
    #1;
    for (int k = 1; k <= 69; k++) begin
      if (k > 1) @(negedge CLK);
      got = {ready, sram_cen, sram_gwen, sram_wen, sram_a, sram_d[1:0]};
      if (k <= 4)       req = {1'b0, 1'b1, got[16:0]};
      else if (k <= 68) req = {1'b0, 1'b0, 1'b0, 8'h00, 6'(k - 5), 2'b00};
      else              req = {1'b1, 1'b1, 1'b1, 8'hFF, 6'd63, 2'b00};
      total++;
      if (got !== req || (k >= 5 && sram_d !== 8'h00)) begin
        bad++;
        $display("FAIL init cycle=%0d got ready=%b cen=%b gwen=%b wen=%h a=%0d d=%h required ready=%b cen=%b gwen=%b wen=%h a=%0d",
                 k, ready, sram_cen, sram_gwen, sram_wen, sram_a, sram_d,
                 req[18], req[17], req[16], req[15:8], req[7:2]);
      end
    end
    model_after_clear();
  endtask

  task automatic test_write_read();
    logic g0, g1;
    cycle(mk(1, 1, 6'd5, 8'hA5, 8'hFF), IDLE, g0, g1);
    cycle(mk(1, 0, 6'd5, 8'h00, 8'h00), IDLE, g0, g1);
    drain(3);
  endtask

  task automatic test_partial();
    logic g0, g1;
    cycle(mk(1, 1, 6'd9, 8'h3C, 8'hFF), IDLE, g0, g1);
    cycle(IDLE, mk(1, 1, 6'd9, 8'hFF, 8'h0F), g0, g1);
    cycle(mk(1, 1, 6'd9, 8'h00, 8'h00), IDLE, g0, g1);
    cycle(IDLE, mk(1, 0, 6'd9, 8'h00, 8'h00), g0, g1);
    drain(3);
  endtask

  task automatic test_alternate();
    logic g0, g1, prev;
    cycle(mk(1, 1, 6'd1, 8'h11, 8'hFF), IDLE, g0, g1);
    cycle(IDLE, mk(1, 1, 6'd2, 8'h22, 8'hFF), g0, g1);
    prev = 1'bx;
    for (int i = 0; i < 8; i++) begin
      cycle(mk(1, 0, 6'd1, 8'h00, 8'h00), mk(1, 0, 6'd2, 8'h00, 8'h00), g0, g1);
      if (i > 0) begin
        total++;
        if (g0 === prev || g0 === g1) begin
          bad++;
          $display("FAIL alternate i=%0d got p0=%b p1=%b required p0=%b", i, g0, g1, ~prev);
        end
      end
      prev = g0;
    end
    drain(3);
  endtask

  task automatic test_random();
    req_t pend0, pend1;
    logic g0, g1;
    pend0 = IDLE; pend1 = IDLE;
    for (int i = 0; i < 400; i++) begin
      if (!pend0.req && $urandom_range(0, 3) != 0)
        pend0 = mk(1, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
      if (!pend1.req && $urandom_range(0, 3) != 0)
        pend1 = mk(1, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
      cycle(pend0, pend1, g0, g1);
      if (g0) pend0.req = 1'b0;
      if (g1) pend1.req = 1'b0;
    end
    drain(3);
  endtask

  task automatic test_midreset();
    logic g0, g1;
    cycle(mk(1, 1, 6'd5, 8'hA5, 8'hFF), IDLE, g0, g1);
    cycle(IDLE, mk(1, 0, 6'd5, 8'h00, 8'h00), g0, g1);
    cen_not_rst = 1'b1;
    p0_req = 1'b0; p1_req = 1'b0;
    #1;
    total++;
    if ({sram_cen, ready, p0_rvalid, p1_rvalid} !== 4'b1000) begin
      bad++;
      $display("FAIL midreset got cen=%b ready=%b rvalid=%b%b required cen=1 ready=0 rvalid=00",
               sram_cen, ready, p0_rvalid, p1_rvalid);
    end
    @(negedge CLK);
    total++;
    if ({sram_cen, p0_rvalid, p1_rvalid} !== 3'b100) begin
      bad++;
      $display("FAIL midreset_drop got cen=%b rvalid=%b%b required cen=1 rvalid=00",
               sram_cen, p0_rvalid, p1_rvalid);
    end
    exp_q.delete();
    @(negedge CLK);
    test_init();
    cycle(mk(1, 0, 6'd5, 8'h00, 8'h00), IDLE, g0, g1);
    drain(3);
  endtask

  task automatic test_noclear();
    @(negedge CLK);
    n_p0_req = 1'b1; n_p1_req = 1'b1;
    rst2 = 1'b0;
    #1;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) @(negedge CLK);
      total++;
      if ({n_ready, n_p0_gnt, n_p1_gnt} !== ((k == 5) ? 3'b110 : 3'b000)) begin
        bad++;
        $display("FAIL noclear cycle=%0d got ready=%b gnt=%b%b required %b",
                 k, n_ready, n_p0_gnt, n_p1_gnt, (k == 5) ? 3'b110 : 3'b000);
      end
    end
    n_p0_req = 1'b0; n_p1_req = 1'b0;
  endtask

  initial begin
    cyc = 0;
    tb_ready = 1'b0;
    test_reset();
    test_init();
    test_write_read();
    test_partial();
    test_alternate();
    test_random();
    test_midreset();
    test_noclear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
